// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- asynchronous serial receiver (8N1, LSB first).
// Synchronises the rx line, detects start bits, samples each bit at mid-period,
// checks the stop bit and hands completed bytes to the consumer through a
// valid/ready holding register.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames.
// This adds a PARITY state and a parity_err_o output pulse.
module uart_rx_byte #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    // First wait lands on the middle of the start bit, later waits span a full bit.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(32'd1);
    localparam logic [BIT_W-1:0] LAST_IDX  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic even_parity_bad(input logic [DATA_BITS-1:0] data,
                                             input logic                 par);
        return (^data) ^ par;
    endfunction
`endif

    // Synchroniser and state registers
    logic                 sync1_r;
    logic                 sync2_r;
    logic                 rx_s;
    state_t               state_r;
    state_t               state_nx_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nx_s;
    logic [BIT_W-1:0]     bit_idx_r;
    logic [BIT_W-1:0]     bit_idx_nx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nx_s;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_nx_s;
    logic                 valid_r;
    logic                 valid_nx_s;
    logic                 frame_err_r;
    logic                 frame_err_nx_s;
    logic                 overrun_r;
    logic                 overrun_nx_s;
    logic                 busy_r;
    logic                 busy_nx_s;
    logic                 tick_s;
    logic                 last_bit_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_r;
    logic                 par_bad_nx_s;
    logic                 parity_err_r;
    logic                 parity_err_nx_s;
`endif

    assign rx_s       = sync2_r;
    assign tick_s     = (cnt_r == CNT_ZERO);
    assign last_bit_s = (bit_idx_r == LAST_IDX);

    // Two-flop synchroniser for the asynchronous rx line (resets to idle-high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            sync2_r <= sync1_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!rx_s) state_nx_s = S_START;
                else       state_nx_s = S_IDLE;
            end
            S_START: begin
                // A high line at mid start bit was only a glitch.
                if (tick_s) state_nx_s = rx_s ? S_IDLE : S_DATA;
                else        state_nx_s = S_START;
            end
            S_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (tick_s && last_bit_s) state_nx_s = S_PARITY;
                else                      state_nx_s = S_DATA;
`else
                if (tick_s && last_bit_s) state_nx_s = S_STOP;
                else                      state_nx_s = S_DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_s) state_nx_s = S_STOP;
                else        state_nx_s = S_PARITY;
            end
`endif
            S_STOP: begin
                if (tick_s) state_nx_s = rx_s ? S_IDLE : S_WAIT_IDLE;
                else        state_nx_s = S_STOP;
            end
            S_WAIT_IDLE: begin
                // Hold off until the line is released so a break is not seen as a start.
                if (rx_s) state_nx_s = S_IDLE;
                else      state_nx_s = S_WAIT_IDLE;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Datapath and output next values driven by the current state
    always_comb begin
        cnt_nx_s       = (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : CNT_ZERO;
        bit_idx_nx_s   = bit_idx_r;
        shift_nx_s     = shift_r;
        data_nx_s      = data_r;
        // The consumer's acceptance drops valid unless a new byte loads below.
        valid_nx_s     = (valid_r && ready_i) ? 1'b0 : valid_r;
        frame_err_nx_s = 1'b0;
        overrun_nx_s   = 1'b0;
        busy_nx_s      = (state_nx_s != S_IDLE);
`ifdef UART_RX_PARITY_EN
        par_bad_nx_s    = par_bad_r;
        parity_err_nx_s = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_nx_s     = HALF_LOAD;
                    bit_idx_nx_s = BIT_ZERO;
                end else begin
                    cnt_nx_s     = CNT_ZERO;
                end
            end
            S_START: begin
                if (tick_s && !rx_s) begin
                    cnt_nx_s     = FULL_LOAD;
                    bit_idx_nx_s = BIT_ZERO;
                end else begin
                    bit_idx_nx_s = bit_idx_r;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    // LSB arrives first, so shift in from the top.
                    shift_nx_s   = {rx_s, shift_r[DATA_BITS-1:1]};
                    bit_idx_nx_s = bit_idx_r + BIT_ONE;
                    cnt_nx_s     = FULL_LOAD;
                end else begin
                    shift_nx_s   = shift_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_s) begin
                    par_bad_nx_s = even_parity_bad(shift_r, rx_s);
                    cnt_nx_s     = FULL_LOAD;
                end else begin
                    par_bad_nx_s = par_bad_r;
                end
            end
`endif
            S_STOP: begin
                if (tick_s) begin
                    cnt_nx_s = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
                    parity_err_nx_s = par_bad_r;
`endif
                    if (rx_s) begin
                        if (!valid_r || ready_i) begin
                            data_nx_s  = shift_r;
                            valid_nx_s = 1'b1;
                        end else begin
                            // Holding register still full: keep the old byte.
                            overrun_nx_s = 1'b1;
                        end
                    end else begin
                        frame_err_nx_s = 1'b1;
                    end
                end else begin
                    data_nx_s = data_r;
                end
            end
            S_WAIT_IDLE: begin
                cnt_nx_s = CNT_ZERO;
            end
            default: begin
                cnt_nx_s = CNT_ZERO;
            end
        endcase
    end

    // Datapath and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= BIT_ZERO;
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            cnt_r       <= cnt_nx_s;
            bit_idx_r   <= bit_idx_nx_s;
            shift_r     <= shift_nx_s;
            data_r      <= data_nx_s;
            valid_r     <= valid_nx_s;
            frame_err_r <= frame_err_nx_s;
            overrun_r   <= overrun_nx_s;
            busy_r      <= busy_nx_s;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= par_bad_nx_s;
            parity_err_r <= parity_err_nx_s;
`endif
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;
    assign busy_o      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte: table of single frames, plus hand-written
// sequences for overrun, break/framing error, glitch and mid-frame reset.
// Received bytes are checked against a scoreboard queue filled as frames are sent.
module tb_uart_rx_byte;
    localparam int CLK_DIV   = 16;
    localparam int DATA_BITS = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    int total = 0;
    int bad   = 0;
    int valid_cycles = 0;
    int ferr_cycles  = 0;
    int ovr_cycles   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_rx_byte #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    // Line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    // Scoreboard monitor: counts pulses and compares accepted bytes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o)     valid_cycles++;
            if (frame_err_o) ferr_cycles++;
            if (overrun_o)   ovr_cycles++;
            if (frame_err_o || overrun_o)
                check("pulse_excl", {31'd0, frame_err_o & overrun_o}, 32'd0);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte actual=%02h required=none", data_o);
                end else begin
                    check("rx_byte", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int f0;
        int o0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h55, stop: 1'b0, exp_valid: 0, exp_ferr: 1};
        vecs[4] = '{data: 8'h0F, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[6] = '{data: 8'h81, stop: 1'b1, exp_valid: 1, exp_ferr: 0};

        // Reset with the line toggling
        rst_n   = 1'b0;
        rx_i    = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 rx_i = ~rx_i;
        end
        @(negedge clk);
        check("rst_data",  {24'd0, data_o},  32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
        check("rst_ovr",   {31'd0, overrun_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        @(posedge clk); #1;
        rx_i  = 1'b1;
        rst_n = 1'b1;
        send_bit(1'b1);

        // Table of single frames with ready_i held high
        for (int i = 0; i < 7; i++) begin
            v0 = valid_cycles;
            f0 = ferr_cycles;
            o0 = ovr_cycles;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            send_bit(1'b1);
            send_bit(1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), ferr_cycles - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_cycles - o0, 32'd0);
            check($sformatf("vec%0d_busy", i), {31'd0, busy_o}, 32'd0);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 32'd0);
            @(posedge clk); #1;
        end

        // Back-to-back frames with consumer stalled: second byte overruns
        ready_i = 1'b0;
        o0 = ovr_cycles;
        f0 = ferr_cycles;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("ovr_pulses", ovr_cycles - o0, 32'd1);
        check("ovr_ferr", ferr_cycles - f0, 32'd0);
        check("ovr_data_held", {24'd0, data_o}, 32'h3C);
        check("ovr_valid_held", {31'd0, valid_o}, 32'd1);
        @(posedge clk); #1 ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovr_valid_drop", {31'd0, valid_o}, 32'd0);
        check("ovr_pending", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // Framing error followed by a long break
        v0 = valid_cycles;
        f0 = ferr_cycles;
        send_frame(8'h55, 1'b0);
        repeat (20 * CLK_DIV) @(posedge clk);
        @(negedge clk);
        check("brk_busy_mid", {31'd0, busy_o}, 32'd1);
        repeat (20 * CLK_DIV) @(posedge clk);
        @(negedge clk);
        check("brk_busy_end", {31'd0, busy_o}, 32'd1);
        check("brk_ferr", ferr_cycles - f0, 32'd1);
        check("brk_valid", valid_cycles - v0, 32'd0);
        @(posedge clk); #1 rx_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("brk_busy_release", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        send_bit(1'b1);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("brk_next_pending", exp_q.size(), 32'd0);
        check("brk_next_data", {24'd0, data_o}, 32'h0F);
        @(posedge clk); #1;

        // Short low glitch: FSM leaves IDLE then returns with no output
        v0 = valid_cycles;
        f0 = ferr_cycles;
        rx_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_rise", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1 rx_i = 1'b1;
        repeat (CLK_DIV / 2 + 3 - 4) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_fall", {31'd0, busy_o}, 32'd0);
        send_bit(1'b1);
        check("glitch_valid", valid_cycles - v0, 32'd0);
        check("glitch_ferr", ferr_cycles - f0, 32'd0);

        // Reset in the middle of 0xFF, then a clean 0x81
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_data", {24'd0, data_o}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send_bit(1'b1);
        v0 = valid_cycles;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("midrst_valid_cycles", valid_cycles - v0, 32'd1);
        check("midrst_next_data", {24'd0, data_o}, 32'h81);
        check("final_pending", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
